// File: rtl/i2c_pkg.sv
`default_nettype none
// ==================================================================
// i2c_pkg : command codes, FSM states and per-phase line drive table
// Rev 1.0
// ==================================================================
package i2c_pkg;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [4:0] {
    IDLE,
    START_A, START_B, START_C, START_D,
    STOP_A,  STOP_B,  STOP_C,  STOP_D,
    WR_A,    WR_B,    WR_C,    WR_D,
    RD_A,    RD_B,    RD_C,    RD_D
  } state_t;

  typedef enum logic [1:0] {
    PH_A, PH_B, PH_C, PH_D
  } phase_t;

  function automatic phase_t phase_of(state_t s);
    phase_t p;
    p = PH_A;
    case (s)
      START_B, STOP_B, WR_B, RD_B: p = PH_B;
      START_C, STOP_C, WR_C, RD_C: p = PH_C;
      START_D, STOP_D, WR_D, RD_D: p = PH_D;
      default:                     p = PH_A;
    endcase
    return p;
  endfunction

  function automatic state_t first_state(logic [1:0] cmd);
    state_t s;
    case (cmd)
      CMD_START: s = START_A;
      CMD_STOP:  s = STOP_A;
      CMD_WRITE: s = WR_A;
      default:   s = RD_A;
    endcase
    return s;
  endfunction

  function automatic state_t next_state(state_t s);
    state_t n;
    case (s)
      START_A: n = START_B;
      START_B: n = START_C;
      START_C: n = START_D;
      STOP_A:  n = STOP_B;
      STOP_B:  n = STOP_C;
      STOP_C:  n = STOP_D;
      WR_A:    n = WR_B;
      WR_B:    n = WR_C;
      WR_C:    n = WR_D;
      RD_A:    n = RD_B;
      RD_B:    n = RD_C;
      RD_C:    n = RD_D;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // Returns {scl, sda}; START_A keeps SCL where it was so a repeated START
  // releases SCL only in phase B.
  function automatic logic [1:0] phase_drive(state_t s, logic din, logic cur_scl);
    logic [1:0] d;
    case (s)
      START_A:        d = {cur_scl, 1'b1};
      START_B:        d = 2'b11;
      START_C:        d = 2'b10;
      START_D:        d = 2'b00;
      STOP_A:         d = 2'b00;
      STOP_B:         d = 2'b10;
      STOP_C, STOP_D: d = 2'b11;
      WR_A, WR_D:     d = {1'b0, din};
      WR_B, WR_C:     d = {1'b1, din};
      RD_A, RD_D:     d = 2'b01;
      RD_B, RD_C:     d = 2'b11;
      default:        d = 2'b11;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bit_gen_if.sv
`default_nettype none
// ==================================================================
// i2c_bit_gen_if : command handshake between byte controller and bit engine
// Rev 1.0
// ==================================================================
interface i2c_bit_gen_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       din;
  logic       dout;
  logic       done;
  logic       arb_lost;
  logic       bus_owner;

  modport master (
    output cmd_valid, cmd, din,
    input  cmd_ready, dout, done, arb_lost, bus_owner
  );

  modport slave (
    input  cmd_valid, cmd, din,
    output cmd_ready, dout, done, arb_lost, bus_owner
  );

endinterface
`default_nettype wire

// File: rtl/i2c_phase_timer.sv
`default_nettype none
// ==================================================================
// i2c_phase_timer : loadable quarter-bit down-counter with stretch hold
// Rev 1.0
// ==================================================================
module i2c_phase_timer #(
  parameter int DIV_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [DIV_W-1:0] i_load_val,
  input  wire logic             i_hold,
  output logic                  o_zero
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/i2c_bit_gen.sv
`default_nettype none
// ==================================================================
// i2c_bit_gen : bit-level I2C initiator (START/STOP/WRITE/READ sequences)
// Rev 1.0
// ==================================================================
module i2c_bit_gen
  import i2c_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [DIV_W-1:0] clk_div,
  i2c_bit_gen_if.slave          cmd_if,
  input  wire logic             scl_i,
  input  wire logic             sda_i,
  input  wire logic             sto_det,
  output logic                  scl_o,
  output logic                  sda_o
);

  state_t r_state;
  logic   r_din;
  logic   r_scl_o;
  logic   r_sda_o;
  logic   r_done;
  logic   r_arb_lost;
  logic   r_dout;
  logic   r_bus_owner;

  logic   w_busy;
  logic   w_hold;
  logic   w_zero;
  logic   w_phase_end;
  logic   w_load;
  logic   w_is_stop;
  logic   w_arb_window;
  logic   w_arb;
  logic   w_idle_sto;
  phase_t w_phase;
  state_t w_first;
  state_t w_next;

  assign w_busy      = (r_state != IDLE);
  assign w_phase     = phase_of(r_state);
  assign w_first     = first_state(cmd_if.cmd);
  assign w_next      = next_state(r_state);
  // Another device holding SCL low while we release it freezes the phase.
  assign w_hold      = r_scl_o & ~scl_i;
  assign w_phase_end = w_busy & w_zero & ~w_hold;
  assign w_load      = (~w_busy & cmd_if.cmd_valid) | (w_phase_end & (w_phase != PH_D));

  assign w_is_stop    = (r_state == STOP_A) | (r_state == STOP_B) |
                        (r_state == STOP_C) | (r_state == STOP_D);
  assign w_arb_window = (r_state == START_B) | (r_state == STOP_C) |
                        (r_state == STOP_D)  | ((r_state == WR_C) & r_din);
  assign w_arb        = w_busy &
                        ((w_arb_window & r_sda_o & scl_i & ~sda_i) |
                         (sto_det & r_bus_owner & ~w_is_stop));
  // A foreign STOP while idle still costs us the bus; no command is aborted.
  assign w_idle_sto   = ~w_busy & sto_det & r_bus_owner;

  i2c_phase_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (clk_div),
    .i_hold     (w_hold),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_din       <= 1'b0;
      r_scl_o     <= 1'b1;
      r_sda_o     <= 1'b1;
      r_done      <= 1'b0;
      r_arb_lost  <= 1'b0;
      r_dout      <= 1'b0;
      r_bus_owner <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_arb_lost <= 1'b0;
      if (!w_busy) begin
        if (w_idle_sto) begin
          r_arb_lost  <= 1'b1;
          r_bus_owner <= 1'b0;
        end
        if (cmd_if.cmd_valid) begin
          r_state            <= w_first;
          r_din              <= cmd_if.din;
          {r_scl_o, r_sda_o} <= phase_drive(w_first, cmd_if.din, r_scl_o);
        end
      end else if (w_arb) begin
        r_state     <= IDLE;
        r_scl_o     <= 1'b1;
        r_sda_o     <= 1'b1;
        r_arb_lost  <= 1'b1;
        r_bus_owner <= 1'b0;
      end else if (w_phase_end) begin
        if (r_state == RD_C) begin
          r_dout <= sda_i;
        end
        if (w_phase == PH_D) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
          if (r_state == START_D) begin
            r_bus_owner <= 1'b1;
          end
          if (r_state == STOP_D) begin
            r_bus_owner <= 1'b0;
          end
        end else begin
          r_state            <= w_next;
          {r_scl_o, r_sda_o} <= phase_drive(w_next, r_din, r_scl_o);
        end
      end
    end
  end

  assign scl_o            = r_scl_o;
  assign sda_o            = r_sda_o;
  assign cmd_if.cmd_ready = ~w_busy;
  assign cmd_if.dout      = r_dout;
  assign cmd_if.done      = r_done;
  assign cmd_if.arb_lost  = r_arb_lost;
  assign cmd_if.bus_owner = r_bus_owner;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bit_gen.sv
`default_nettype none
// ==================================================================
// tb_i2c_bit_gen : directed self-checking bench for i2c_bit_gen
// Rev 1.0
// ==================================================================
module tb_i2c_bit_gen;
  import i2c_pkg::*;

  localparam int DIV_W = 16;
  localparam int LIMIT = 300;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] clk_div = 16'd4;
  logic             scl_i;
  logic             sda_i;
  logic             sto_det = 1'b0;
  logic             scl_o;
  logic             sda_o;
  logic             sda_force = 1'b0;
  logic             stretch = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   lat;
  logic done_seen;
  logic arb_seen;
  int   sda_fall;
  int   sda_rise;
  int   scl_fall;
  logic scl_at_fall;
  logic scl_at_rise;

  i2c_bit_gen_if u_if ();

  // Open-drain bus: the bench can only pull lines low.
  assign scl_i = scl_o & ~stretch;
  assign sda_i = sda_o & ~sda_force;

  always #5 clk = ~clk;

  i2c_bit_gen #(
    .DIV_W (DIV_W)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .clk_div (clk_div),
    .cmd_if  (u_if.slave),
    .scl_i   (scl_i),
    .sda_i   (sda_i),
    .sto_det (sto_det),
    .scl_o   (scl_o),
    .sda_o   (sda_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Issues one command and runs until done/arb_lost. lat counts cycles from
  // the accept cycle T (lat=k means the event is seen in cycle T+k).
  task automatic run_cmd(input logic [1:0] c, input logic d,
                         input int f_lo, input int f_hi,
                         input int s_lo, input int s_hi, input int st_len);
    logic p_scl;
    logic p_sda;
    int   stc;
    @(negedge clk);
    u_if.cmd       = c;
    u_if.din       = d;
    u_if.cmd_valid = 1'b1;
    p_scl     = scl_o;
    p_sda     = sda_o;
    stretch   = (st_len > 0);
    stc       = 0;
    done_seen = 1'b0;
    arb_seen  = 1'b0;
    sda_fall  = 0;
    sda_rise  = 0;
    scl_fall  = 0;
    scl_at_fall = 1'b0;
    scl_at_rise = 1'b0;
    @(posedge clk);
    lat = 1;
    while (lat < LIMIT) begin
      @(negedge clk);
      u_if.cmd_valid = 1'b0;
      if (u_if.done) begin
        done_seen = 1'b1;
        break;
      end
      if (u_if.arb_lost) begin
        arb_seen = 1'b1;
        break;
      end
      if (p_sda && !sda_o && sda_fall == 0) begin
        sda_fall    = lat;
        scl_at_fall = scl_o;
      end
      if (!p_sda && sda_o && sda_rise == 0) begin
        sda_rise    = lat;
        scl_at_rise = scl_o;
      end
      if (p_scl && !scl_o && scl_fall == 0) scl_fall = lat;
      p_scl     = scl_o;
      p_sda     = sda_o;
      sda_force = (lat >= f_lo) && (lat <= f_hi);
      sto_det   = (lat >= s_lo) && (lat <= s_hi);
      if (stretch && scl_o) begin
        stc++;
        if (stc > st_len) stretch = 1'b0;
      end
      @(posedge clk);
      lat++;
    end
    sda_force = 1'b0;
    sto_det   = 1'b0;
    stretch   = 1'b0;
    check("cmd_finished", {31'd0, done_seen | arb_seen}, 32'd1);
  endtask

  initial begin
    u_if.cmd_valid = 1'b0;
    u_if.cmd       = CMD_START;
    u_if.din       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_scl_o",     {31'd0, scl_o},          32'd1);
    check("rst_sda_o",     {31'd0, sda_o},          32'd1);
    check("rst_cmd_ready", {31'd0, u_if.cmd_ready}, 32'd1);
    check("rst_done",      {31'd0, u_if.done},      32'd0);
    check("rst_arb_lost",  {31'd0, u_if.arb_lost},  32'd0);
    check("rst_dout",      {31'd0, u_if.dout},      32'd0);
    check("rst_bus_owner", {31'd0, u_if.bus_owner}, 32'd0);

    // START, clk_div=4
    clk_div = 16'd4;
    run_cmd(CMD_START, 1'b0, 0, 0, 0, 0, 0);
    check("start_sda_fall",   sda_fall, 32'd11);
    check("start_scl_hi_fall", {31'd0, scl_at_fall}, 32'd1);
    check("start_scl_fall",   scl_fall, 32'd16);
    check("start_done_lat",   lat, 32'd21);
    check("start_done",       {31'd0, done_seen}, 32'd1);
    check("start_owner",      {31'd0, u_if.bus_owner}, 32'd1);
    check("start_ready",      {31'd0, u_if.cmd_ready}, 32'd1);

    // WRITE din=1, clk_div=2
    clk_div = 16'd2;
    run_cmd(CMD_WRITE, 1'b1, 0, 0, 0, 0, 0);
    check("wr_done_lat", lat, 32'd13);
    check("wr_no_arb",   {31'd0, arb_seen}, 32'd0);
    check("wr_scl_low",  {31'd0, scl_o}, 32'd0);
    check("wr_sda_hold", {31'd0, sda_o}, 32'd1);

    // READ with clk_div=0: 1-cycle phases, bus left high
    clk_div = 16'd0;
    run_cmd(CMD_READ, 1'b0, 0, 0, 0, 0, 0);
    check("rd0_done_lat", lat, 32'd5);
    check("rd0_dout",     {31'd0, u_if.dout}, 32'd1);

    // READ, clk_div=2, SDA pulled low in phase C (cycles 7..9)
    clk_div = 16'd2;
    run_cmd(CMD_READ, 1'b0, 7, 9, 0, 0, 0);
    check("rd_done_lat", lat, 32'd13);
    check("rd_dout",     {31'd0, u_if.dout}, 32'd0);
    check("rd_no_arb",   {31'd0, arb_seen}, 32'd0);

    // Stretch: SCL held low 50 cycles once released in phase B
    clk_div = 16'd4;
    run_cmd(CMD_WRITE, 1'b0, 0, 0, 0, 0, 50);
    check("stretch_done_lat", lat, 32'd71);
    check("stretch_done",     {31'd0, done_seen}, 32'd1);

    // Arbitration loss in WRITE phase C
    clk_div = 16'd2;
    run_cmd(CMD_WRITE, 1'b1, 7, 9, 0, 0, 0);
    check("arb_seen",  {31'd0, arb_seen}, 32'd1);
    check("arb_no_done", {31'd0, done_seen}, 32'd0);
    check("arb_lat",   lat, 32'd8);
    check("arb_scl_o", {31'd0, scl_o}, 32'd1);
    check("arb_sda_o", {31'd0, sda_o}, 32'd1);
    check("arb_owner", {31'd0, u_if.bus_owner}, 32'd0);
    @(negedge clk);
    check("arb_pulse_end", {31'd0, u_if.arb_lost}, 32'd0);

    // START, WRITE, STOP with clk_div=3; sto_det during STOP C/D is ignored
    clk_div = 16'd3;
    run_cmd(CMD_START, 1'b0, 0, 0, 0, 0, 0);
    check("start3_done_lat", lat, 32'd17);
    run_cmd(CMD_WRITE, 1'b1, 0, 0, 0, 0, 0);
    check("wr3_done_lat", lat, 32'd17);
    run_cmd(CMD_STOP, 1'b0, 0, 0, 9, 16, 0);
    check("stop_sda_rise",    sda_rise, 32'd9);
    check("stop_scl_hi_rise", {31'd0, scl_at_rise}, 32'd1);
    check("stop_done_lat",    lat, 32'd17);
    check("stop_done",        {31'd0, done_seen}, 32'd1);
    check("stop_owner",       {31'd0, u_if.bus_owner}, 32'd0);
    check("stop_scl_o",       {31'd0, scl_o}, 32'd1);
    check("stop_sda_o",       {31'd0, sda_o}, 32'd1);

    // Reset during WRITE phase B (cycle T+5 with clk_div=2)
    clk_div = 16'd2;
    @(negedge clk);
    u_if.cmd       = CMD_WRITE;
    u_if.din       = 1'b0;
    u_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst_sda_o", {31'd0, sda_o}, 32'd0);
    check("pre_rst_ready", {31'd0, u_if.cmd_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_scl_o", {31'd0, scl_o}, 32'd1);
    check("mid_rst_sda_o", {31'd0, sda_o}, 32'd1);
    check("mid_rst_ready", {31'd0, u_if.cmd_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_cmd(CMD_START, 1'b0, 0, 0, 0, 0, 0);
    check("post_rst_done_lat", lat, 32'd13);
    check("post_rst_owner",    {31'd0, u_if.bus_owner}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
